mc_sample_gen: RTL

Pseudo-random sample-point source for the Monte Carlo datapath. Generates a programmed number of (x, y) operand pairs from two independent 16-bit LFSRs and presents them to the downstream function evaluator (t = a·x + b·y) over a valid/ready handshake. It counts accepted samples and flags completion so the accumulation stage knows when a run has ended.

---
 rtl/mc_sample_gen.sv | 119 +++++++++++
 1 files changed

// File: rtl/mc_sample_gen.sv
// Monte Carlo sample-point source: two 16-bit Fibonacci LFSRs stream (x, y) pairs
// over valid/ready for a programmed number of samples per run.
//
// state  | meaning
// IDLE   | waiting for start; seeds may be loaded
// RUN    | presenting samples, counting accepted transfers
// DONE   | run complete; done_o sticky until next start
module mc_sample_gen #(
    parameter int          WIDTH     = 10,
    parameter int          N_SAMPLES = 1024,
    parameter logic [15:0] SEED_X    = 16'hACE1,
    parameter logic [15:0] SEED_Y    = 16'h1D87,
    localparam int         CW        = $clog2(N_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             seed_load,
    input  logic [15:0]      seed_x,
    input  logic [15:0]      seed_y,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CW-1:0]    count_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CW-1:0] N_LAST = CW'(N_SAMPLES);

    state_t        state_q, state_d;
    logic [15:0]   lfsr_x_q, lfsr_x_d;
    logic [15:0]   lfsr_y_q, lfsr_y_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Taps 16,14,13,11: maximal length, so the all-zero state is never entered.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

    always_comb begin
        state_d  = state_q;
        lfsr_x_d = lfsr_x_q;
        lfsr_y_d = lfsr_y_q;
        count_d  = count_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // Seeds load on the same edge as start so the run begins from them.
                if (seed_load) begin
                    lfsr_x_d = (seed_x == 16'd0) ? SEED_X : seed_x;
                    lfsr_y_d = (seed_y == 16'd0) ? SEED_Y : seed_y;
                end
                if (start) begin
                    state_d = S_RUN;
                    count_d = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (valid_q && ready_i) begin
                    lfsr_x_d = lfsr_step(lfsr_x_q);
                    lfsr_y_d = lfsr_step(lfsr_y_q);
                    count_d  = count_q + CW'(1);
                    if (count_d == N_LAST) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lfsr_x_q <= SEED_X;
            lfsr_y_q <= SEED_Y;
            count_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_x_q <= lfsr_x_d;
            lfsr_y_q <= lfsr_y_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x_o     = lfsr_x_q[WIDTH-1:0];
    assign y_o     = lfsr_y_q[WIDTH-1:0];
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign count_o = count_q;

endmodule
